// File: rtl/alt_xcvr_rcfg_profile_streamer_if.sv
// Signal bundle between the profile streamer, its reconfiguration ROM and the
// native PHY reconfig slave. The streamer sits on the master modport.
interface alt_xcvr_rcfg_profile_streamer_if #(
  parameter int ROM_DATA_WIDTH = 26,
  parameter int ROM_ADDR_W     = 2
);
  logic                      cfg_load;
  logic [7:0]                cfg_sel;
  logic                      cfg_busy;
  logic                      cfg_done;
  logic                      cfg_error;
  logic [ROM_ADDR_W-1:0]     rom_addr;
  logic [ROM_DATA_WIDTH-1:0] rom_rdata;
  logic [9:0]                avmm_address;
  logic                      avmm_read;
  logic                      avmm_write;
  logic [31:0]               avmm_writedata;
  logic [31:0]               avmm_readdata;
  logic                      avmm_waitrequest;

  modport master (
    input  cfg_load, cfg_sel, rom_rdata, avmm_readdata, avmm_waitrequest,
    output cfg_busy, cfg_done, cfg_error, rom_addr,
           avmm_address, avmm_read, avmm_write, avmm_writedata
  );

  modport slave (
    output cfg_load, cfg_sel, rom_rdata, avmm_readdata, avmm_waitrequest,
    input  cfg_busy, cfg_done, cfg_error, rom_addr,
           avmm_address, avmm_read, avmm_write, avmm_writedata
  );
endinterface

// File: rtl/alt_xcvr_rcfg_profile_streamer.sv
// Walks one end-marker-terminated profile of the reconfiguration ROM and applies
// each word as a masked read-modify-write on the transceiver AVMM reconfig port.
module alt_xcvr_rcfg_profile_streamer #(
  parameter int ROM_DATA_WIDTH = 26,
  parameter int ROM_DEPTH      = 4,
  parameter int NUM_PROFILES   = 2,
  parameter int ROM_ADDR_W     = 2
) (
  input logic                             clk,
  input logic                             reset,
  alt_xcvr_rcfg_profile_streamer_if.master bus
);

  localparam logic [7:0]            NUM_PROF_B = 8'(NUM_PROFILES);
  localparam logic [ROM_ADDR_W-1:0] LAST_PTR   = ROM_ADDR_W'(ROM_DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_RD     = 3'd3,
    S_WR     = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [ROM_ADDR_W-1:0] r_ptr;
  logic [7:0]            r_mcnt;
  logic [7:0]            r_sel;
  logic [9:0]            r_addr;
  logic [7:0]            r_mask;
  logic [7:0]            r_data;
  logic [7:0]            r_rdbyte;
  logic [7:0]            r_wdata;
  logic                  r_done;
  logic                  r_error;
  logic                  r_read;
  logic                  r_write;

  logic                  w_start;
  logic                  w_ptr_inc;
  logic                  w_mcnt_inc;
  logic                  w_latch;
  logic                  w_rd_done;
  logic                  w_err;
  logic                  w_marker;
  logic                  w_last;
  logic [9:0]            w_rom_addr;
  logic [7:0]            w_rom_mask;
  logic [7:0]            w_rom_data;
  logic                  w_unused_rdata;

  function automatic logic [7:0] merge_byte(input logic [7:0] old_b,
                                            input logic [7:0] mask_b,
                                            input logic [7:0] data_b);
    return (old_b & ~mask_b) | (data_b & mask_b);
  endfunction

  assign w_marker       = &bus.rom_rdata;
  assign w_last         = (r_ptr == LAST_PTR);
  assign w_rom_addr     = bus.rom_rdata[ROM_DATA_WIDTH-1 -: 10];
  assign w_rom_mask     = bus.rom_rdata[15:8];
  assign w_rom_data     = bus.rom_rdata[7:0];
  assign w_unused_rdata = ^bus.avmm_readdata[31:8];

  assign bus.cfg_busy       = (r_state != S_IDLE);
  assign bus.cfg_done       = r_done;
  assign bus.cfg_error      = r_error;
  assign bus.rom_addr       = r_ptr;
  assign bus.avmm_address   = r_addr;
  assign bus.avmm_read      = r_read;
  assign bus.avmm_write     = r_write;
  assign bus.avmm_writedata = {24'h000000, r_wdata};

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode and per-cycle control strobes
  always_comb begin
    w_next     = r_state;
    w_start    = 1'b0;
    w_ptr_inc  = 1'b0;
    w_mcnt_inc = 1'b0;
    w_latch    = 1'b0;
    w_rd_done  = 1'b0;
    w_err      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.cfg_load) begin
          if (bus.cfg_sel < NUM_PROF_B) begin
            w_start = 1'b1;
            w_next  = S_FETCH;
          end else begin
            w_err = 1'b1;
          end
        end else begin
          w_next = S_IDLE;
        end
      end
      S_FETCH: w_next = S_DECODE;
      S_DECODE: begin
        if (r_mcnt < r_sel) begin
          // Seeking the start of the selected profile; markers only count here
          w_mcnt_inc = w_marker;
          if (w_last) begin
            w_err  = 1'b1;
            w_next = S_IDLE;
          end else begin
            w_ptr_inc = 1'b1;
            w_next    = S_FETCH;
          end
        end else if (w_marker) begin
          w_next = S_DONE;
        end else begin
          w_latch = 1'b1;
          w_next  = (w_rom_mask == 8'hFF) ? S_WR : S_RD;
        end
      end
      S_RD: begin
        if (!bus.avmm_waitrequest) begin
          w_rd_done = 1'b1;
          w_next    = S_WR;
        end else begin
          w_next = S_RD;
        end
      end
      S_WR: begin
        if (!bus.avmm_waitrequest) begin
          if (w_last) begin
            w_err  = 1'b1;
            w_next = S_IDLE;
          end else begin
            w_ptr_inc = 1'b1;
            w_next    = S_FETCH;
          end
        end else begin
          w_next = S_WR;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath and registered outputs; strobes follow the state being entered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr    <= '0;
      r_mcnt   <= 8'h00;
      r_sel    <= 8'h00;
      r_addr   <= 10'h000;
      r_mask   <= 8'h00;
      r_data   <= 8'h00;
      r_rdbyte <= 8'h00;
      r_wdata  <= 8'h00;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
      r_read   <= 1'b0;
      r_write  <= 1'b0;
    end else begin
      r_done  <= (w_next == S_DONE);
      r_error <= w_err;
      r_read  <= (w_next == S_RD);
      r_write <= (w_next == S_WR);
      if (w_start) begin
        r_sel  <= bus.cfg_sel;
        r_ptr  <= '0;
        r_mcnt <= 8'h00;
      end else if (w_ptr_inc) begin
        r_ptr <= r_ptr + ROM_ADDR_W'(1);
      end
      if (w_mcnt_inc) begin
        r_mcnt <= r_mcnt + 8'd1;
      end
      if (w_latch) begin
        r_addr  <= w_rom_addr;
        r_mask  <= w_rom_mask;
        r_data  <= w_rom_data;
        // Full-mask words skip the read; the merge then yields data unchanged
        r_wdata <= merge_byte(r_rdbyte, w_rom_mask, w_rom_data);
      end
      if (w_rd_done) begin
        r_rdbyte <= bus.avmm_readdata[7:0];
        r_wdata  <= merge_byte(bus.avmm_readdata[7:0], r_mask, r_data);
      end
    end
  end

endmodule
